muldiv_hilo_ctrl: RTL and testbench
===================================

# muldiv_hilo_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It accepts R-form MULT, MULTU, DIV, DIVU, MTHI and MTLO operations, using the operands read from the register file (Rdata1 = rs, Rdata2 = rt). It runs an iterative 32-step shift-add or restoring-divide state machine and commits HI/LO. While it works, it raises Busy so the pipeline stalls; MFHI/MFLO read the Hi/Lo outputs.

## Interface
- WIDTH, 32: operand and HI/LO width; iteration count equals WIDTH
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- Start  in  1  operation request, sampled on rising edge
- Funct  in  6  R-form function field: MTHI=0x11, MTLO=0x13, MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B
- Rdata1  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- Rdata2  in  WIDTH  rt operand (multiplier / divisor)
- Busy  out  1  high while an operation is in flight (state != IDLE)
- Done  out  1  one-cycle pulse after HI/LO commit of a MULT/DIV op
- Hi  out  WIDTH  registered HI
- Lo  out  WIDTH  registered LO

## Operation
- States: IDLE, CALC, FIX.
- IDLE with Start=1:
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes, result signs and op kind; clear step counter; go to CALC.
  - MTHI/MTLO: write Hi/Lo from Rdata1 at that edge; stay in IDLE; no Done pulse.
  - Any other Funct: ignored.
- Start while Busy=1: ignored entirely; the pipeline must hold the instruction until Busy falls.
- Signed ops (MULT, DIV): operands are converted to magnitudes at accept. Unsigned ops use operands as-is.
- CALC, multiply: one shift-add step per cycle over a 2*WIDTH accumulator.
- CALC, divide: one restoring-division step per cycle (shift remainder, trial subtract, set quotient bit).
- CALC lasts exactly WIDTH cycles, counted by the step counter, then goes to FIX.
- FIX applies signs and writes Hi/Lo at the edge leaving FIX, then goes to IDLE with Done=1.
  - MULT: 64-bit two's-complement product; HI = upper word, LO = lower word.
  - DIV: quotient truncates toward zero and goes to LO. Remainder takes the sign of the dividend and goes to HI.
- Divisor = 0 (DIV or DIVU): LO = all-ones, HI = the original dividend (Rdata1 as latched). Takes the same full latency.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
- Hi/Lo hold their previous values throughout CALC/FIX; MFHI/MFLO issued during Busy must be stalled by the pipeline.

## Timing
- Reset (asynchronous, immediate): state=IDLE, Busy=0, Done=0, Hi=0, Lo=0, counter and accumulators 0. Reset mid-operation aborts the op with no partial HI/LO commit.
- Accept at edge E0 (Start=1 in cycle 0).
- Busy = 1 in cycles 1..WIDTH+1, i.e. 1..33: CALC occupies cycles 1..32, FIX is cycle 33.
- Hi/Lo take new values at the edge ending cycle 33 and are visible in cycle 34.
- Done = 1 in cycle 34 only; Busy = 0 in cycle 34.
- A new Start in cycle 34 is accepted (back-to-back throughput: one op per 34 cycles).
- MTHI/MTLO latency: 1 edge; value visible on Hi/Lo the next cycle. Busy is never asserted.
- Busy and Done are registered (decoded from the state register); they have no combinational path from Start.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, Start in cycle 0 -> Busy in cycles 1-33, Done in cycle 34, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT -3 × 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU 100 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000064, Done in cycle 34. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 in consecutive cycles -> Hi/Lo updated one cycle after each, Busy/Done stay 0. MTHI with Start during Busy -> Hi unchanged at Done.
- DIVU 10/3 accepted, second Start (MULTU 5×5) held high in cycles 1-33 -> ignored. Start still high in cycle 34 is accepted, giving Hi=1, Lo=3 after the first op and Hi=0, Lo=25 after the second, with Done in cycles 34 and 68.
- MULTU started, RST pulsed asynchronously mid-cycle 10 -> Busy, Done, Hi, Lo all 0 immediately. A new MULTU 2×3 after release -> Lo=6 with full 34-cycle latency.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_if.sv
// Pipeline <-> HI/LO multiply/divide unit bus.
// master: pipeline side (drives Start/Funct/Rdata*), slave: the unit.
interface muldiv_hilo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] Rdata1;
    logic [WIDTH-1:0] Rdata2;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Funct, Rdata1, Rdata2,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Funct, Rdata1, Rdata2,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MTHI/MTLO write direct.
// Ports: CLK, RST (async, high), bus (slave): Start/Funct/Rdata1/Rdata2 in,
// Busy/Done/Hi/Lo out.
module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic CLK,
    input  logic RST,
    muldiv_hilo_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               accept;
    logic               f_md;
    logic               f_div;
    logic               f_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Operation decode
    always_comb begin
        f_md     = 1'b0;
        f_div    = 1'b0;
        f_signed = 1'b0;
        case (bus.Funct)
            F_MULT:  begin f_md = 1'b1; f_signed = 1'b1; end
            F_MULTU: begin f_md = 1'b1; end
            F_DIV:   begin f_md = 1'b1; f_div = 1'b1; f_signed = 1'b1; end
            F_DIVU:  begin f_md = 1'b1; f_div = 1'b1; end
            default: ;
        endcase
    end

    assign accept = bus.Start && (state == IDLE);
    assign a_neg  = f_signed & bus.Rdata1[WIDTH-1];
    assign b_neg  = f_signed & bus.Rdata2[WIDTH-1];
    assign mag_a  = a_neg ? -bus.Rdata1 : bus.Rdata1;
    assign mag_b  = b_neg ? -bus.Rdata2 : bus.Rdata2;

    // One iteration step.
    // Multiply: acc = {partial, multiplier}, shifted right each step.
    // Divide:   acc = {remainder, dividend->quotient}, shifted left.
    always_comb begin
        sum      = '0;
        trial    = '0;
        acc_step = acc;
        if (is_div) begin
            trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
            if (!trial[WIDTH])
                acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opb} : '0);
            acc_step = {sum, acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied in FIX
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            // Divide-by-zero leaves rem = |dividend|; the sign fix
            // restores the original dividend, so only LO needs forcing.
            res_lo = dz ? '1 : (neg_q ? -quo : quo);
            res_hi = neg_r ? -rem : rem;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept && f_md) state_nx = CALC;
            CALC:    if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (accept && f_md) begin
                        cnt    <= '0;
                        is_div <= f_div;
                        dz     <= f_div && (bus.Rdata2 == '0);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (f_div) begin
                            acc <= {{WIDTH{1'b0}}, mag_a};
                            opb <= mag_b;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, mag_b};
                            opb <= mag_a;
                        end
                    end else if (accept && bus.Funct == F_MTHI) begin
                        hi_q <= bus.Rdata1;
                    end else if (accept && bus.Funct == F_MTLO) begin
                        lo_q <= bus.Rdata1;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl: directed cases plus random ops
// against an arithmetic reference model.
module tb_muldiv_hilo_ctrl;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } md_exp_t;

    typedef struct {
        int          cyc;
        logic        sel_hi;
        logic [31:0] val;
    } mt_exp_t;

    logic CLK;
    logic RST;
    int   cyc = 0;
    int   last_acc = -1000;
    int   n_cmp = 0;
    int   n_bad = 0;

    md_exp_t     md_q[$];
    mt_exp_t     mt_q[$];
    logic [31:0] vis_hi = '0;
    logic [31:0] vis_lo = '0;

    muldiv_hilo_ctrl_if #(.WIDTH(32)) bus();

    muldiv_hilo_ctrl #(.WIDTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [5:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        int     qs;
        int     rs;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (f)
            MULT:  r = sa * sb;
            MULTU: r = {32'h0, a} * {32'h0, b};
            DIV: begin
                if (b == 0)
                    r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'h0, 32'h8000_0000};
                else begin
                    qs = $signed(a) / $signed(b);
                    rs = $signed(a) % $signed(b);
                    r  = {rs, qs};
                end
            end
            DIVU: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic bit model_idle();
        return (cyc >= last_acc + 34);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        logic [63:0] r;
        bus.Start  = 1'b1;
        bus.Funct  = f;
        bus.Rdata1 = a;
        bus.Rdata2 = b;
        if (model_idle()) begin
            if (f inside {MULT, MULTU, DIV, DIVU}) begin
                r = ref_md(f, a, b);
                md_q.push_back('{hi: r[63:32], lo: r[31:0], cyc: cyc + 34});
                last_acc = cyc;
            end else if (f == MTHI) begin
                mt_q.push_back('{cyc: cyc + 1, sel_hi: 1'b1, val: a});
            end else if (f == MTLO) begin
                mt_q.push_back('{cyc: cyc + 1, sel_hi: 1'b0, val: a});
            end
        end
        step(1);
        bus.Start = 1'b0;
    endtask

    task automatic wait_idle();
        while (!model_idle()) step(1);
    endtask

    task automatic model_reset();
        md_q.delete();
        mt_q.delete();
        vis_hi   = '0;
        vis_lo   = '0;
        last_acc = -1000;
    endtask

    // Monitor: Done pops the scoreboard; Busy/Hi/Lo checked every cycle
    logic    exp_done;
    logic    exp_busy;
    md_exp_t e;
    always @(negedge CLK) begin
        while (mt_q.size() > 0 && mt_q[0].cyc <= cyc) begin
            if (mt_q[0].sel_hi) vis_hi = mt_q[0].val;
            else                vis_lo = mt_q[0].val;
            void'(mt_q.pop_front());
        end
        exp_done = (md_q.size() > 0 && md_q[0].cyc == cyc);
        exp_busy = (cyc > last_acc && cyc <= last_acc + 33);
        chk("done", 64'(bus.Done), 64'(exp_done));
        if (bus.Done && md_q.size() > 0) begin
            e = md_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("result_hi", 64'(bus.Hi), 64'(e.hi));
            chk("result_lo", 64'(bus.Lo), 64'(e.lo));
            vis_hi = e.hi;
            vis_lo = e.lo;
        end else if (md_q.size() > 0 && md_q[0].cyc < cyc) begin
            e = md_q.pop_front();
            chk("done_timeout", 64'(cyc), 64'(e.cyc));
        end
        chk("busy", 64'(bus.Busy), 64'(exp_busy));
        chk("hi", 64'(bus.Hi), 64'(vis_hi));
        chk("lo", 64'(bus.Lo), 64'(vis_lo));
    end

    logic [5:0]  fsel [8];
    logic [31:0] corner [6];

    function automatic logic [31:0] rnd_opnd();
        if ($urandom_range(0, 3) == 0)
            return corner[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) == 0)
            return 32'($urandom_range(0, 50)) - 32'd25;
        return $urandom;
    endfunction

    initial begin
        fsel   = '{MTHI, MTLO, MULT, MULTU, DIV, DIVU, 6'h10, 6'h00};
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                   32'h7FFF_FFFF, 32'h2};
        bus.Start  = 1'b0;
        bus.Funct  = '0;
        bus.Rdata1 = '0;
        bus.Rdata2 = '0;
        RST = 1'b0;
        #1 RST = 1'b1;
        step(3);
        chk("reset_busy", 64'(bus.Busy), 64'd0);
        chk("reset_hi", 64'(bus.Hi), 64'd0);
        RST = 1'b0;
        step(1);

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        chk("multu_max_hi", 64'(bus.Hi), 64'hFFFF_FFFE);
        chk("multu_max_lo", 64'(bus.Lo), 64'h1);

        issue(MULT, -32'sd3, 32'd7);
        wait_idle();
        chk("mult_neg_hi", 64'(bus.Hi), 64'hFFFF_FFFF);
        chk("mult_neg_lo", 64'(bus.Lo), 64'hFFFF_FFEB);
        issue(DIV, -32'sd7, 32'd2);
        wait_idle();
        chk("div_neg_lo", 64'(bus.Lo), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(bus.Hi), 64'hFFFF_FFFF);

        issue(DIVU, 32'd100, 32'd0);
        wait_idle();
        chk("divz_lo", 64'(bus.Lo), 64'hFFFF_FFFF);
        chk("divz_hi", 64'(bus.Hi), 64'h64);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        chk("div_ovf_lo", 64'(bus.Lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(bus.Hi), 64'h0);
        issue(DIV, -32'sd9, 32'd0);
        wait_idle();
        chk("sdivz_hi", 64'(bus.Hi), 64'hFFFF_FFF7);

        issue(MTHI, 32'h1234_5678, 32'h0);
        chk("mthi", 64'(bus.Hi), 64'h1234_5678);
        issue(MTLO, 32'h9ABC_DEF0, 32'h0);
        chk("mtlo", 64'(bus.Lo), 64'h9ABC_DEF0);
        chk("mt_busy", 64'(bus.Busy), 64'd0);

        issue(MULTU, 32'd3, 32'd4);
        issue(MTHI, 32'hDEAD_BEEF, 32'h0);
        wait_idle();
        chk("mthi_busy_hi", 64'(bus.Hi), 64'h0);

        issue(DIVU, 32'd10, 32'd3);
        repeat (34) issue(MULTU, 32'd5, 32'd5);
        chk("b2b_first_hi", 64'(bus.Hi), 64'h1);
        chk("b2b_first_lo", 64'(bus.Lo), 64'h3);
        wait_idle();
        chk("b2b_second_hi", 64'(bus.Hi), 64'h0);
        chk("b2b_second_lo", 64'(bus.Lo), 64'd25);

        issue(MULTU, 32'hABCD_1234, 32'h0000_F00F);
        step(9);
        #2 RST = 1'b1;
        model_reset();
        #1;
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_hi", 64'(bus.Hi), 64'd0);
        chk("rst_lo", 64'(bus.Lo), 64'd0);
        step(2);
        RST = 1'b0;
        issue(MULTU, 32'd2, 32'd3);
        wait_idle();
        chk("post_rst_lo", 64'(bus.Lo), 64'd6);

        for (int i = 0; i < 80; i++) begin
            issue(fsel[$urandom_range(0, 7)], rnd_opnd(), rnd_opnd());
            step($urandom_range(0, 40));
        end
        wait_idle();
        step(3);
        chk("drain", 64'(md_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
